imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between two requesters: CPU fetch
//  (F) and program loader/debug port (L). One access per cycle; synchronous
//  memory with 1-cycle read latency. Round-robin on contention; L can lock the
//  port for multi-word bursts. Sits between the fetch stage and instr_mem.
// PARAMETERS
//  ADDR_W     32  byte-address width of both requesters
//  DATA_W     32  instruction word width
//  IDX_LO     2   low bit of word index taken from byte address
//  IDX_W      16  memory word-index width (index = addr[IDX_LO+IDX_W-1:IDX_LO])
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  f_req      in   1       fetch read request
//  f_addr     in   ADDR_W  fetch byte address
//  f_gnt      out  1       fetch request accepted this cycle (combinational)
//  f_rvalid   out  1       fetch read data valid (registered)
//  f_rdata    out  DATA_W  fetch read data
//  f_err      out  1       with f_rvalid: access was misaligned
//  l_req      in   1       loader request
//  l_we       in   1       loader write (1) / read (0)
//  l_lock     in   1       loader keeps ownership while l_req stays high
//  l_addr     in   ADDR_W  loader byte address
//  l_wdata    in   DATA_W  loader write data
//  l_gnt      out  1       loader request accepted this cycle (combinational)
//  l_rvalid   out  1       loader read data valid (registered; reads only)
//  l_rdata    out  DATA_W  loader read data
//  l_err      out  1       with l_rvalid, or with l_gnt on writes: misaligned
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable
//  mem_idx    out  IDX_W   memory word index
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset (reset==0, async): f_rvalid, l_rvalid, f_err, l_err = 0; f_rdata,
//    l_rdata = 0; owner register = L (so F wins first contention); lock = 0.
//    Read in flight at reset is dropped; no rvalid after reset release.
//  - Grant, cycle N: only f_req -> F; only l_req -> L; both -> lock held by L
//    -> L, else requester not equal to owner register. Exactly one gnt max.
//  - On grant: owner <= granted side; lock <= l_lock & (granted==L).
//    Lock clears when L granted with l_lock=0 or when l_req drops (cycle of drop).
//  - Granted & aligned: mem_en=1, mem_idx=addr index bits, mem_we=l_we for L,
//    0 for F. Ungranted/idle: mem_en=0, mem_we=0.
//  - Misaligned (addr[IDX_LO-1:0]!=0): granted, mem_en=0, no memory write;
//    read: rvalid in N+1 with rdata=0, err=1; L write: l_err=1 with l_gnt in N.
//  - Read latency: rvalid/rdata/err registered, asserted in N+1 for one cycle
//    per grant; back-to-back grants give back-to-back rvalid. Writes: no rvalid.
//  - Requester must hold req/addr/data stable until gnt; deasserting before gnt
//    is legal and cancels the request with no side effects.
//  - Address bits above IDX_LO+IDX_W-1 ignored (wrap-around on memory size).
//  - States: OWN_F, OWN_L, LOCK_L (owner+lock). OWN_x -> OWN_y on grant to y;
//    OWN_L -> LOCK_L on L grant with l_lock; LOCK_L -> OWN_L on l_lock=0 or
//    l_req=0; F never granted in LOCK_L while l_req=1.
// TESTING
//  - Reset, f_req=1 addr 0x0,0x4,0x8 back-to-back -> f_gnt each cycle;
//    f_rvalid N+1..N+3 with mem words 0,1,2; l_* idle.
//  - f_req & l_req both held 4 cycles -> grants F,L,F,L; each rvalid on
//    correct side one cycle later with matching data.
//  - L writes 0xDEADBEEF to 0x10 with l_lock=1 for 3 beats while f_req=1 ->
//    F stalled 3 cycles; then l_lock=0 -> F granted next; F reads 0x10 = 0xDEADBEEF.
//  - f_addr=0x6 -> f_gnt, mem_en=0, f_rvalid next cycle with f_rdata=0,
//    f_err=1; l write to 0x3 -> l_err=1, mem_we never asserted.
//  - reset asserted in cycle after F grant -> f_rvalid stays 0, outputs zero;
//    after release first contention granted to F.

Source files
------------

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch (F) and the
// loader/debug port (L): round-robin on contention, with L burst locking.
module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_LO = 2,
    parameter int IDX_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {OWN_F, OWN_L, LOCK_L} state_t;

    state_t state, state_nxt;

    logic f_mis, l_mis;
    logic f_vld_p1, f_err_p1;
    logic l_vld_p1, l_err_p1;
    logic addr_unused;

    assign f_mis = |f_addr[IDX_LO-1:0];
    assign l_mis = |l_addr[IDX_LO-1:0];

    // Bits above the memory index wrap around; they never reach the memory.
    assign addr_unused = ^{f_addr[ADDR_W-1:IDX_LO+IDX_W], l_addr[ADDR_W-1:IDX_LO+IDX_W]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= OWN_L;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        state_nxt = state;
        if (f_req && l_req) begin
            // Held lock or F owning last means L goes; otherwise F's turn.
            if (state == OWN_L) begin
                f_gnt = 1'b1;
            end else begin
                l_gnt = 1'b1;
            end
        end else if (f_req) begin
            f_gnt = 1'b1;
        end else if (l_req) begin
            l_gnt = 1'b1;
        end

        if (l_gnt) begin
            state_nxt = l_lock ? LOCK_L : OWN_L;
        end else if (f_gnt) begin
            state_nxt = OWN_F;
        end else if (state == LOCK_L) begin
            state_nxt = OWN_L;
        end
    end

    always_comb begin
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        mem_idx = f_addr[IDX_LO+IDX_W-1:IDX_LO];
        if (l_gnt) begin
            mem_idx = l_addr[IDX_LO+IDX_W-1:IDX_LO];
            mem_en  = !l_mis;
            mem_we  = l_we && !l_mis;
        end else if (f_gnt) begin
            mem_en  = !f_mis;
        end
    end

    assign mem_wdata = l_wdata;

    // Stage p0 -> p1: grant cycle to read-response cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            f_vld_p1 <= 1'b0;
            f_err_p1 <= 1'b0;
            l_vld_p1 <= 1'b0;
            l_err_p1 <= 1'b0;
        end else begin
            f_vld_p1 <= f_gnt;
            f_err_p1 <= f_gnt && f_mis;
            l_vld_p1 <= l_gnt && !l_we;
            l_err_p1 <= l_gnt && !l_we && l_mis;
        end
    end

    assign f_rvalid = f_vld_p1;
    assign f_err    = f_err_p1;
    assign f_rdata  = (f_vld_p1 && !f_err_p1) ? mem_rdata : '0;
    assign l_rvalid = l_vld_p1;
    assign l_rdata  = (l_vld_p1 && !l_err_p1) ? mem_rdata : '0;
    // Misaligned writes report at grant time since they produce no response.
    assign l_err    = l_err_p1 || (l_gnt && l_we && l_mis);

endmodule
